// File: rtl/amm_burst_slave_mem.sv
// Avalon-MM burst slave backed by on-chip word memory.
// Single and burst writes with byteenable; single and burst reads at a fixed read latency.
// Illegal master behaviour sets a sticky protocol_err.
module amm_burst_slave_mem #(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned BURST_W      = 11,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     address,
  input  logic                  read,
  input  logic                  write,
  input  logic [DATA_W-1:0]     writedata,
  input  logic [DATA_W/8-1:0]   byteenable,
  input  logic [BURST_W-1:0]    burstcount,
  output logic                  readdatavalid,
  output logic [DATA_W-1:0]     readdata,
  output logic                  waitrequest,
  output logic                  protocol_err
);

  localparam int unsigned BeW     = DATA_W / 8;
  localparam int unsigned LatW    = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
  // RD_WAIT lasts READ_LATENCY-1 cycles; the counter runs down to zero.
  localparam int unsigned LatInit = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;

  typedef enum logic [1:0] {StIdle, StWrBurst, StRdWait, StRdBurst} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BURST_W-1:0]  cnt_q, cnt_d;
  logic [LatW-1:0]     lat_q, lat_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q, err_d;

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic [BURST_W-1:0]  bc_eff;

  logic [DATA_W-1:0]   mem [2**ADDR_W];

  assign waitrequest   = (state_q == StRdWait) || (state_q == StRdBurst);
  assign bc_eff        = (burstcount == '0) ? BURST_W'(1) : burstcount;
  assign readdatavalid = rvalid_q;
  assign readdata      = rdata_q;
  assign protocol_err  = err_q;

  // Next-state, address/count bookkeeping and memory port controls.
  // In the read path addr_q/cnt_q refer to the beat after the one being presented.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    lat_d    = lat_q;
    rvalid_d = 1'b0;
    err_d    = err_q;
    wr_en    = 1'b0;
    wr_addr  = addr_q;
    rd_en    = 1'b0;
    rd_addr  = addr_q;

    // Read together with write, or read inside a write burst, is illegal.
    if (read && !waitrequest && (write || state_q == StWrBurst)) begin
      err_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (write) begin
          wr_en   = 1'b1;
          wr_addr = address;
          addr_d  = address + 1'b1;
          cnt_d   = bc_eff - 1'b1;
          if (bc_eff != BURST_W'(1)) state_d = StWrBurst;
        end else if (read) begin
          if (READ_LATENCY == 1) begin
            rd_en    = 1'b1;
            rd_addr  = address;
            rvalid_d = 1'b1;
            addr_d   = address + 1'b1;
            cnt_d    = bc_eff - 1'b1;
            state_d  = StRdBurst;
          end else begin
            addr_d  = address;
            cnt_d   = bc_eff;
            lat_d   = LatW'(LatInit);
            state_d = StRdWait;
          end
        end
      end
      StWrBurst: begin
        if (write) begin
          wr_en  = 1'b1;
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == BURST_W'(1)) state_d = StIdle;
        end
      end
      StRdWait: begin
        if (lat_q == '0) begin
          rd_en    = 1'b1;
          rvalid_d = 1'b1;
          addr_d   = addr_q + 1'b1;
          cnt_d    = cnt_q - 1'b1;
          state_d  = StRdBurst;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      StRdBurst: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          rd_en    = 1'b1;
          rvalid_d = 1'b1;
          addr_d   = addr_q + 1'b1;
          cnt_d    = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state and registered read response; readdata holds after a burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      cnt_q    <= '0;
      lat_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      lat_q    <= lat_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      if (rd_en) rdata_q <= mem[rd_addr];
    end
  end

  // Byte-lane masked memory write; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BeW; i++) begin
        if (byteenable[i]) mem[wr_addr][i*8 +: 8] <= writedata[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_amm_burst_slave_mem.sv
// Self-checking bench for amm_burst_slave_mem: directed scenarios plus random bursts
// checked against an array model of memory and the protocol timing rules.
module tb_amm_burst_slave_mem;

  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 32;
  localparam int unsigned BW    = 11;
  localparam int unsigned RL    = 2;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] address = '0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [DW-1:0] writedata = '0;
  logic [3:0]    byteenable = '0;
  logic [BW-1:0] burstcount = '0;
  logic          readdatavalid;
  logic [DW-1:0] readdata;
  logic          waitrequest;
  logic          protocol_err;

  amm_burst_slave_mem #(
    .ADDR_W(AW), .DATA_W(DW), .BURST_W(BW), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .burstcount(burstcount),
    .readdatavalid(readdatavalid), .readdata(readdata), .waitrequest(waitrequest),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  logic [DW-1:0] model [DEPTH];
  logic          err_exp = 1'b0;
  logic [DW-1:0] wq[$];
  logic [3:0]    bq[$];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [3:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  // Write burst using wq/bq; optional one-cycle gap after beat gap_after; read is
  // asserted alongside every beat from rd_from on (-1 = never). Called at a negedge.
  task automatic wr_burst(input logic [AW-1:0] a, input int bc, input int gap_after,
                          input int rd_from);
    int n;
    int guard;
    logic [AW-1:0] idx;
    n = (bc == 0) ? 1 : bc;
    for (int i = 0; i < n; i++) begin
      write      = 1'b1;
      writedata  = wq[i];
      byteenable = bq[i];
      if (i == 0) begin
        address    = a;
        burstcount = BW'(bc);
      end else begin
        address    = AW'($urandom);
        burstcount = BW'($urandom);
      end
      read  = (rd_from >= 0) && (i >= rd_from);
      guard = 0;
      while (waitrequest && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      chk("wr_accept_in_time", 32'(guard < 50), 32'd1);
      @(negedge clk);
      idx        = a + AW'(i);
      model[idx] = merge(model[idx], wq[i], bq[i]);
      if (read) err_exp = 1'b1;
      if (i == gap_after) begin
        write = 1'b0;
        read  = 1'b0;
        @(negedge clk);
      end
    end
    write = 1'b0;
    read  = 1'b0;
    chk("perr_after_wr", 32'(protocol_err), 32'(err_exp));
  endtask

  // Read burst, checking latency, waitrequest, data and the trailing idle cycle.
  task automatic rd_burst(input logic [AW-1:0] a, input int bc);
    int n;
    int cyc;
    logic [AW-1:0] idx;
    n          = (bc == 0) ? 1 : bc;
    address    = a;
    burstcount = BW'(bc);
    read       = 1'b1;
    chk("rd_accept_wreq", 32'(waitrequest), 32'd0);
    @(negedge clk);
    read       = 1'b0;
    address    = AW'($urandom);
    burstcount = BW'($urandom);
    cyc = 1;
    while (!readdatavalid && cyc < 20) begin
      chk("rd_wait_wreq", 32'(waitrequest), 32'd1);
      @(negedge clk);
      cyc++;
    end
    chk("rd_latency", 32'(cyc), 32'(RL));
    for (int k = 0; k < n; k++) begin
      idx = a + AW'(k);
      chk("rd_valid", 32'(readdatavalid), 32'd1);
      chk("rd_beat_wreq", 32'(waitrequest), 32'd1);
      chk("rd_data", readdata, model[idx]);
      @(negedge clk);
    end
    chk("rd_valid_end", 32'(readdatavalid), 32'd0);
    chk("rd_wreq_end", 32'(waitrequest), 32'd0);
    chk("perr_after_rd", 32'(protocol_err), 32'(err_exp));
  endtask

  initial begin
    int n;
    int bc;
    int gap;
    logic [AW-1:0] a;
    logic [DW-1:0] last;

    // Reset values
    #12;
    chk("rst_rvalid", 32'(readdatavalid), 32'd0);
    chk("rst_rdata", readdata, 32'd0);
    chk("rst_wreq", 32'(waitrequest), 32'd0);
    chk("rst_perr", 32'(protocol_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill the whole memory with one 1024-beat burst so every model word is known.
    wq.delete(); bq.delete();
    for (int i = 0; i < DEPTH; i++) begin
      wq.push_back($urandom);
      bq.push_back(4'hF);
    end
    wr_burst(10'h000, DEPTH, -1, -1);
    rd_burst(10'h000, 4);
    rd_burst(10'h3FE, 2);

    // Single write then single read
    wq.delete(); bq.delete();
    wq.push_back(32'hDEADBEEF); bq.push_back(4'hF);
    wr_burst(10'd5, 1, -1, -1);
    rd_burst(10'd5, 1);
    chk("single_rdata", readdata, 32'hDEADBEEF);

    // 4-beat write with a gap after beat 2, read back as a burst
    wq.delete(); bq.delete();
    for (int i = 1; i <= 4; i++) begin
      wq.push_back(32'(i));
      bq.push_back(4'hF);
    end
    wr_burst(10'h010, 4, 1, -1);
    rd_burst(10'h010, 4);

    // Byteenable merge
    wq.delete(); bq.delete();
    wq.push_back(32'hFFFFFFFF); bq.push_back(4'hF);
    wr_burst(10'd3, 1, -1, -1);
    wq.delete(); bq.delete();
    wq.push_back(32'h12345678); bq.push_back(4'h5);
    wr_burst(10'd3, 1, -1, -1);
    rd_burst(10'd3, 1);
    chk("be_rdata", readdata, 32'hFF34FF78);

    // Wrap-around on write and read
    wq.delete(); bq.delete();
    for (int i = 0; i < 3; i++) begin
      wq.push_back(32'hA000_0000 + 32'(i));
      bq.push_back(4'hF);
    end
    wr_burst(10'h3FF, 3, -1, -1);
    rd_burst(10'h3FF, 1);
    chk("wrap_3ff", readdata, 32'hA000_0000);
    rd_burst(10'h000, 2);
    chk("wrap_001", readdata, 32'hA000_0002);

    // burstcount of 0 behaves as a single beat
    wq.delete(); bq.delete();
    wq.push_back(32'h0BAD_F00D); bq.push_back(4'hF);
    wr_burst(10'h040, 0, -1, -1);
    rd_burst(10'h040, 0);

    // read+write together in IDLE: write wins, no response, sticky error
    wq.delete(); bq.delete();
    wq.push_back(32'hC0FFEE01); bq.push_back(4'hF);
    wr_burst(10'h020, 1, -1, 0);
    for (int i = 0; i < 4; i++) begin
      chk("perr_no_rvalid", 32'(readdatavalid), 32'd0);
      chk("perr_sticky", 32'(protocol_err), 32'd1);
      @(negedge clk);
    end
    // read during a write burst is ignored; burst completes
    wq.delete(); bq.delete();
    for (int i = 0; i < 3; i++) begin
      wq.push_back($urandom);
      bq.push_back(4'hF);
    end
    wr_burst(10'h030, 3, -1, 1);
    chk("perr_wrburst_no_rvalid", 32'(readdatavalid), 32'd0);
    rd_burst(10'h020, 1);
    rd_burst(10'h030, 3);

    // Random bursts against the model
    for (int it = 0; it < 40; it++) begin
      a  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(DEPTH - 6, DEPTH - 1))
                                       : AW'($urandom);
      n  = $urandom_range(1, 8);
      bc = (n == 1 && $urandom_range(0, 3) == 0) ? 0 : n;
      if ($urandom_range(0, 1) == 0) begin
        wq.delete(); bq.delete();
        for (int i = 0; i < n; i++) begin
          wq.push_back($urandom);
          bq.push_back(4'($urandom));
        end
        gap = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
        wr_burst(a, bc, gap, -1);
      end else begin
        rd_burst(a, bc);
      end
    end

    // Reset in the middle of an 8-beat read
    address    = 10'h100;
    burstcount = BW'(8);
    read       = 1'b1;
    @(negedge clk);
    read = 1'b0;
    n = 0;
    while (!readdatavalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    a = 10'h100;
    chk("rstmid_beat0", readdata, model[a]);
    @(negedge clk);
    a = 10'h101;
    chk("rstmid_beat1", readdata, model[a]);
    #2 rst_n = 1'b0;
    #1;
    err_exp = 1'b0;
    chk("rstmid_rvalid", 32'(readdatavalid), 32'd0);
    chk("rstmid_wreq", 32'(waitrequest), 32'd0);
    chk("rstmid_perr", 32'(protocol_err), 32'd0);
    chk("rstmid_rdata", readdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("rstmid_no_beats", 32'(readdatavalid), 32'd0);
      @(negedge clk);
    end
    rd_burst(10'h105, 1);
    last = readdata;
    a = 10'h105;
    chk("rstmid_mem_kept", last, model[a]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
